// File: rtl/tcp_rx_payload.sv
// tcp_rx_payload: receive-side Ethernet/IPv4/TCP parser that forwards only the
// TCP payload bytes of frames addressed to the local MAC and TCP port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, ignore bytes until newpkt
// ETH     | Ethernet header, offsets 0-13 (dest MAC, ethertype)
// IP      | IPv4 header incl. options, ip = off-14 up to hlen-1
// TCP     | TCP header incl. options, t = off-14-hlen up to thlen-1
// PAYLOAD | forward each valid byte, plen counts down to 0
// DROP    | frame rejected or finished, ignore bytes until newpkt
module tcp_rx_payload #(
  parameter logic [15:0] port = 16'd80,
  parameter logic [47:0] mac  = 48'hC471FEC856BF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       dataValid,
  input  logic [7:0] data,
  input  logic       newpkt,
  output logic       outDataValid,
  output logic [7:0] outData
);

  typedef enum logic [2:0] {
    S_IDLE, S_ETH, S_IP, S_TCP, S_PAYLOAD, S_DROP
  } state_t;

  state_t      state, state_nxt, cur_state;
  logic [15:0] off, off_nxt, cur_off;
  logic [15:0] ip, t;
  logic [7:0]  hlen, hlen_nxt;
  logic [7:0]  thlen, thlen_nxt, thlen_v;
  logic [15:0] totlen, totlen_nxt;
  logic [15:0] plen, plen_nxt;
  logic [7:0]  port_hi, port_hi_nxt;
  logic [7:0]  mac_byte;
  logic        out_vld_nxt;
  logic [7:0]  out_nxt;

  // Register the parser state, captured header fields and the output byte.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= S_IDLE;
      off          <= 16'd0;
      hlen         <= 8'd0;
      thlen        <= 8'd0;
      totlen       <= 16'd0;
      plen         <= 16'd0;
      port_hi      <= 8'd0;
      outDataValid <= 1'b0;
      outData      <= 8'd0;
    end else begin
      state        <= state_nxt;
      off          <= off_nxt;
      hlen         <= hlen_nxt;
      thlen        <= thlen_nxt;
      totlen       <= totlen_nxt;
      plen         <= plen_nxt;
      port_hi      <= port_hi_nxt;
      outDataValid <= out_vld_nxt;
      outData      <= out_nxt;
    end
  end

  // Parse the current byte; newpkt restarts the frame so a coincident byte is offset 0.
  always_comb begin
    cur_state   = newpkt ? S_ETH : state;
    cur_off     = newpkt ? 16'd0 : off;
    ip          = cur_off - 16'd14;
    t           = cur_off - 16'd14 - {8'd0, hlen};
    state_nxt   = cur_state;
    off_nxt     = cur_off;
    hlen_nxt    = hlen;
    thlen_nxt   = thlen;
    thlen_v     = {2'b00, data[7:4], 2'b00};
    totlen_nxt  = totlen;
    plen_nxt    = plen;
    port_hi_nxt = port_hi;
    out_vld_nxt = 1'b0;
    out_nxt     = outData;
    case (cur_off[2:0])
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase

    if (dataValid) begin
      off_nxt = (cur_off == 16'hFFFF) ? 16'hFFFF : cur_off + 16'd1;
      case (cur_state)
        S_ETH: begin
          if (cur_off < 16'd6 && data != mac_byte) state_nxt = S_DROP;
          else if (cur_off == 16'd12 && data != 8'h08) state_nxt = S_DROP;
          else if (cur_off == 16'd13) state_nxt = (data == 8'h00) ? S_IP : S_DROP;
        end
        S_IP: begin
          if (ip == 16'd0) begin
            hlen_nxt = {2'b00, data[3:0], 2'b00};
            if (data[7:4] != 4'd4 || data[3:0] < 4'd5) state_nxt = S_DROP;
          end else if (ip == 16'd2) begin
            totlen_nxt = {data, totlen[7:0]};
          end else if (ip == 16'd3) begin
            totlen_nxt = {totlen[15:8], data};
            if ({totlen[15:8], data} < ({8'd0, hlen} + 16'd20)) state_nxt = S_DROP;
          end else if (ip == 16'd9) begin
            if (data != 8'd6) state_nxt = S_DROP;
          end
          if (state_nxt == S_IP && ip == ({8'd0, hlen} - 16'd1)) state_nxt = S_TCP;
        end
        S_TCP: begin
          if (t == 16'd2) begin
            port_hi_nxt = data;
          end else if (t == 16'd3) begin
            if ({port_hi, data} != port) state_nxt = S_DROP;
          end else if (t == 16'd12) begin
            thlen_nxt = thlen_v;
            plen_nxt  = totlen - {8'd0, hlen} - {8'd0, thlen_v};
            if (thlen_v < 8'd20 || ({8'd0, hlen} + {8'd0, thlen_v}) > totlen)
              state_nxt = S_DROP;
          end
          // thlen is only valid once t12 has passed; header end is always beyond it.
          if (state_nxt == S_TCP && t == ({8'd0, thlen} - 16'd1))
            state_nxt = (plen == 16'd0) ? S_DROP : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          out_vld_nxt = 1'b1;
          out_nxt     = data;
          plen_nxt    = plen - 16'd1;
          if (plen == 16'd1) state_nxt = S_DROP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_payload.sv
// tb_tcp_rx_payload: scoreboard bench for tcp_rx_payload. A frame-level
// reference model decides which bytes of each frame are payload; the driver
// queues them with their expected output cycle and a negedge monitor checks.
module tb_tcp_rx_payload;

  localparam logic [47:0] MAC = 48'hC471FEC856BF;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       dataValid;
  logic [7:0] data;
  logic       newpkt;
  logic       outDataValid;
  logic [7:0] outData;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  tcp_rx_payload dut (
    .CLOCK(CLOCK), .RESET(RESET), .dataValid(dataValid), .data(data),
    .newpkt(newpkt), .outDataValid(outDataValid), .outData(outData)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc++;

  // Monitor: every output byte must match the oldest expected byte and cycle.
  always @(negedge CLOCK) begin
    if (!RESET && outDataValid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %02h at cycle %0d, none expected", outData, cyc);
      end else begin
        e = exp_q.pop_front();
        if (outData !== e.d || cyc != e.cyc) begin
          errors++;
          $display("FAIL payload_byte: got %02h at cycle %0d, required %02h at cycle %0d",
                   outData, cyc, e.d, e.cyc);
        end
      end
    end
  end

  // Frame-level reference: which byte range of f is forwarded payload.
  function automatic void model(input bq_t f, output int st, output int ln);
    logic [7:0] b0, b12;
    int hl, tl, tb, thl;
    st = 0;
    ln = 0;
    if (f.size() < 34) return;
    if ({f[0], f[1], f[2], f[3], f[4], f[5]} != MAC) return;
    if ({f[12], f[13]} != 16'h0800) return;
    b0 = f[14];
    if (b0[7:4] != 4'd4 || b0[3:0] < 4'd5) return;
    hl = int'(b0[3:0]) * 4;
    tl = int'({f[16], f[17]});
    if (tl < hl + 20) return;
    if (f[23] != 8'd6) return;
    tb = 14 + hl;
    if (f.size() < tb + 13) return;
    if ({f[tb+2], f[tb+3]} != 16'd80) return;
    b12 = f[tb+12];
    thl = int'(b12[7:4]) * 4;
    if (thl < 20 || hl + thl > tl) return;
    st = tb + thl;
    ln = tl - hl - thl;
    if (st + ln > f.size()) ln = (f.size() > st) ? f.size() - st : 0;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [3:0] ihl, input logic [7:0] proto,
                       input logic [15:0] dport, input logic [3:0] doff,
                       input logic [7:0] flags, input bq_t pl, input int minlen,
                       output bq_t f);
    int hl;
    logic [15:0] tl;
    hl = int'(ihl) * 4;
    tl = 16'(hl + int'(doff) * 4 + pl.size());
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    f.push_back(etype[15:8]); f.push_back(etype[7:0]);
    f.push_back({4'h4, ihl}); f.push_back(8'h00);
    f.push_back(tl[15:8]); f.push_back(tl[7:0]);
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(8'h40); f.push_back(8'h00); f.push_back(8'd64); f.push_back(proto);
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom));
    for (int i = 0; i < hl - 20; i++) f.push_back(8'($urandom));
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(dport[15:8]); f.push_back(dport[7:0]);
    for (int i = 0; i < 8; i++) f.push_back(8'($urandom));
    f.push_back({doff, 4'h0}); f.push_back(flags);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    for (int i = 0; i < int'(doff) * 4 - 20; i++) f.push_back(8'($urandom));
    foreach (pl[i]) f.push_back(pl[i]);
    while (f.size() < minlen) f.push_back(8'h00);
  endtask

  task automatic drive(input logic nv, input logic dv, input logic [7:0] d);
    @(posedge CLOCK);
    #1;
    newpkt = nv;
    dataValid = dv;
    data = d;
  endtask

  // Send f (or its first stop bytes when stop >= 0); gap idles precede each payload byte.
  task automatic send_frame(input bq_t f, input int gap, input bit rgap, input int stop);
    int st, ln, n;
    bit sep;
    model(f, st, ln);
    n = (stop >= 0) ? stop : f.size();
    sep = 1'($urandom_range(0, 1));
    if (sep) drive(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < n; i++) begin
      bit inpl;
      inpl = (i >= st) && (i < st + ln);
      if (inpl) repeat (gap) drive(1'b0, 1'b0, 8'($urandom));
      if (rgap && $urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 8'($urandom));
      drive(i == 0 && !sep, 1'b1, f[i]);
      if (inpl) exp_q.push_back('{d: f[i], cyc: cyc + 1});
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge CLOCK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected bytes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  initial begin
    bq_t f, hello, ok, nopl, pl;
    int st, ln, c, k;

    RESET = 1'b1; dataValid = 1'b0; data = 8'h00; newpkt = 1'b0;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    ok    = '{8'h4F, 8'h4B};
    nopl  = {};
    repeat (3) @(posedge CLOCK);
    #1;
    check_val("reset_valid", {7'd0, outDataValid}, 8'h00);
    check_val("reset_data", outData, 8'h00);
    RESET = 1'b0;

    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1);
    drain("hello");
    check_val("hold_last_valid", {7'd0, outDataValid}, 8'h00);
    check_val("hold_last_data", outData, 8'h4F);

    build(48'hC471FEC856BE, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("wrong_mac");
    build(48'hFFFFFFFFFFFF, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("broadcast");
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd81, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("wrong_port");
    build(MAC, 16'h0806, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("arp_ethertype");
    build(MAC, 16'h0800, 4'd5, 8'd17, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("udp_protocol");

    pl = '{8'hAA, 8'hBB, 8'hCC};
    build(MAC, 16'h0800, 4'd6, 8'd6, 16'd80, 4'd8, 8'h18, pl, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("options");

    pl = '{8'h01, 8'h02};
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, pl, 60, f);
    send_frame(f, 0, 1'b0, -1); drain("padding");

    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h02, nopl, 0, f);
    send_frame(f, 0, 1'b0, -1);
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h12, nopl, 0, f);
    send_frame(f, 0, 1'b0, -1);
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h11, nopl, 0, f);
    send_frame(f, 0, 1'b0, -1);
    drain("syn_synack_fin");
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, ok, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("ok_after_handshake");

    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 3, 1'b0, -1); drain("hello_gaps");

    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    model(f, st, ln);
    send_frame(f, 0, 1'b0, st + 2);
    @(negedge CLOCK);
    #1;
    RESET = 1'b1;
    #1;
    check_val("reset_mid_valid", {7'd0, outDataValid}, 8'h00);
    check_val("reset_mid_data", outData, 8'h00);
    drain("reset_mid_payload");
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    build(MAC, 16'h0800, 4'd5, 8'd6, 16'd80, 4'd5, 8'h18, hello, 0, f);
    send_frame(f, 0, 1'b0, -1); drain("hello_after_reset");

    for (int n = 0; n < 40; n++) begin
      logic [47:0] dm;
      logic [15:0] et, dp;
      logic [7:0]  pr;
      logic [3:0]  ih, dof;
      pl = {};
      k = $urandom_range(0, 24);
      for (int i = 0; i < k; i++) pl.push_back(8'($urandom));
      dm = MAC; et = 16'h0800; pr = 8'd6; dp = 16'd80;
      ih = 4'($urandom_range(5, 7)); dof = 4'($urandom_range(5, 8));
      c = $urandom_range(0, 10);
      case (c)
        5: dm = MAC ^ (48'd1 << $urandom_range(0, 47));
        6: dp = 16'($urandom_range(81, 65535));
        7: et = 16'h86DD;
        8: pr = 8'd17;
        9: if ($urandom_range(0, 1) == 1) ih = 4'd4; else dof = 4'd4;
        default: ;
      endcase
      build(dm, et, ih, pr, dp, dof, 8'h18, pl, ($urandom_range(0, 1) == 1) ? 60 : 0, f);
      if (c == 10) begin
        f[16] = 8'h00;
        f[17] = 8'(int'(ih) * 4 + 10);
      end
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(10, f.size());
        while (f.size() > k) void'(f.pop_back());
      end
      send_frame(f, $urandom_range(0, 2), 1'b1, -1);
    end
    drain("random_frames");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
